// File: rtl/ann_input_sequencer.sv
// Input sequencer for the ANN input-selection datapath: steps the 16-to-1 mux
// select through a programmable number of inputs and streams each word out.
module ann_input_sequencer #(
  parameter  int N_IN = 16,
  parameter  int DW   = 16,
  localparam int SW   = $clog2(N_IN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [SW-1:0] len_m1,
  output logic [SW-1:0] Sel,
  input  logic [DW-1:0] mux_d,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] len_q, len_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          ld;

  // A new word may enter the output register when it is empty or being drained.
  assign ld = !valid_q || out_ready;

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    sel_d   = sel_q;
    len_d   = len_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;

    if (abort) begin
      state_d = IDLE;
      sel_d   = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            len_d   = len_m1;
            sel_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (ld) begin
            data_d  = mux_d;
            valid_d = 1'b1;
            last_d  = (sel_q == len_q);
            if (sel_q == len_q) begin
              state_d = LAST;
            end else begin
              sel_d = sel_q + SW'(1);
            end
          end
        end
        LAST: begin
          if (valid_q && out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            sel_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample
  // the pre-edge values; out_data is reset too, as the interface requires a
  // known zero word out of reset even though valid gates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign Sel       = sel_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_ann_input_sequencer.sv
// Self-checking bench for ann_input_sequencer: a transaction-count model of the
// stream is compared every cycle, plus hand-computed checks per scenario.
module tb_ann_input_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start, abort, out_ready;
  logic [3:0]  len_m1;
  logic [3:0]  Sel;
  logic [15:0] mux_d, out_data;
  logic        out_valid, out_last, busy, done;

  logic [15:0] d_mem [16];
  assign mux_d = d_mem[Sel];

  ann_input_sequencer #(.N_IN(16), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len_m1(len_m1),
    .Sel(Sel), .mux_d(mux_d), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [15:0] got_d[$];
  logic        got_l[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: a pass is a count of words issued into and accepted from the output slot.
  bit          m_in_pass = 0, m_done = 0;
  int          m_len = 0, m_issued = 0, m_accepted = 0;
  logic [15:0] m_data = '0;
  logic        m_valid, m_ld, m_acc, exp_last;
  logic [31:0] exp_sel;

  assign m_valid  = m_in_pass && (m_issued > m_accepted);
  assign m_ld     = m_in_pass && (m_issued < m_len) && (!m_valid || out_ready);
  assign m_acc    = m_valid && out_ready;
  assign exp_last = m_valid && (m_issued == m_len);
  assign exp_sel  = !m_in_pass ? 0 : ((m_issued < m_len) ? m_issued : m_len - 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_pass <= 0; m_done <= 0; m_len <= 0;
      m_issued <= 0; m_accepted <= 0; m_data <= '0;
    end else begin
      m_done <= 0;
      if (abort) begin
        m_in_pass <= 0; m_issued <= 0; m_accepted <= 0;
      end else if (!m_in_pass) begin
        if (start) begin
          m_in_pass <= 1; m_len <= int'(len_m1) + 1;
          m_issued <= 0; m_accepted <= 0;
        end
      end else begin
        if (m_ld) begin
          m_data   <= d_mem[m_issued];
          m_issued <= m_issued + 1;
        end
        if (m_acc) begin
          if (m_accepted + 1 == m_len) begin
            m_in_pass <= 0; m_done <= 1; m_issued <= 0; m_accepted <= 0;
          end else begin
            m_accepted <= m_accepted + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("sel", Sel, exp_sel);
    check("out_valid", out_valid, m_valid);
    check("out_last", out_last, exp_last);
    check("out_data", out_data, m_data);
    check("busy", busy, m_in_pass);
    check("done", done, m_done);
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic do_start(input logic [3:0] l, output int sc);
    @(posedge clk); #2;
    start = 1'b1; len_m1 = l; sc = cyc;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done) begin
        at_cyc = cyc;
        break;
      end
    end
    check({name, "_done_seen"}, (at_cyc >= 0), 1);
  endtask

  task automatic check_stream(input string name, input int n);
    check({name, "_count"}, got_d.size(), n);
    if (got_d.size() == n) begin
      for (int i = 0; i < n; i++) begin
        check({name, "_word"}, got_d[i], d_mem[i]);
        check({name, "_last"}, got_l[i], (i == n - 1));
      end
    end
  endtask

  task automatic clear_stream();
    got_d.delete();
    got_l.delete();
  endtask

  int  sc, dc, done_base;
  bit  stop, found;
  logic [3:0] pat;

  initial begin
    start = 0; abort = 0; len_m1 = 0; out_ready = 1;
    for (int i = 0; i < 16; i++) d_mem[i] = 16'(i + 1);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_sel", Sel, 0);
    check("rst_data", out_data, 0);
    #1 rst_n = 1'b1;

    // Full 16-input pass with continuous ready.
    clear_stream();
    do_start(4'd15, sc);
    wait_done("t1", 40, dc);
    check("t1_latency", dc - sc, 18);
    check_stream("t1", 16);
    if (got_d.size() == 16) begin
      check("t1_w0", got_d[0], 16'h0001);
      check("t1_w15", got_d[15], 16'h0010);
      check("t1_last15", got_l[15], 1);
      check("t1_last14", got_l[14], 0);
    end

    // Single-input pass.
    for (int i = 0; i < 16; i++) d_mem[i] = 16'hA000 + 16'(i);
    clear_stream();
    do_start(4'd0, sc);
    wait_done("t2", 10, dc);
    check("t2_latency", dc - sc, 3);
    check_stream("t2", 1);
    if (got_d.size() == 1) begin
      check("t2_w0", got_d[0], 16'hA000);
      check("t2_l0", got_l[0], 1);
    end

    // Eight inputs with ready toggling 1,0,0,1.
    for (int i = 0; i < 16; i++) d_mem[i] = 16'h0B00 + 16'(i * 3);
    clear_stream();
    pat = 4'b1001;
    stop = 0;
    fork
      begin
        for (int i = 0; !stop; i++) begin
          out_ready = pat[i % 4];
          @(posedge clk); #2;
        end
      end
      begin
        do_start(4'd7, sc);
        wait_done("t3", 100, dc);
        stop = 1;
      end
    join
    out_ready = 1;
    check_stream("t3", 8);
    if (got_d.size() == 8) begin
      check("t3_w0", got_d[0], 16'h0B00);
      check("t3_w7", got_d[7], 16'h0B15);
    end

    // Abort on the 5th word, then a 4-input pass.
    for (int i = 0; i < 16; i++) d_mem[i] = 16'h4000 + 16'(i);
    clear_stream();
    done_base = done_cnt;
    do_start(4'd15, sc);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid && out_data == 16'h4004) begin
        found = 1;
        break;
      end
    end
    check("t4_found_w5", found, 1);
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    #1;
    check("t4_abort_valid", out_valid, 0);
    check("t4_abort_busy", busy, 0);
    check("t4_abort_sel", Sel, 0);
    check("t4_abort_last", out_last, 0);
    repeat (4) @(posedge clk);
    check("t4_no_done", done_cnt, done_base);
    clear_stream();
    do_start(4'd3, sc);
    wait_done("t4b", 20, dc);
    check_stream("t4b", 4);
    if (got_d.size() == 4) check("t4b_w3", got_d[3], 16'h4003);

    // start while busy is ignored; start with abort returns to idle.
    for (int i = 0; i < 16; i++) d_mem[i] = 16'h5000 + 16'(i);
    clear_stream();
    do_start(4'd5, sc);
    @(posedge clk); #2;
    start = 1'b1; len_m1 = 4'd1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done("t5", 30, dc);
    check("t5_latency", dc - sc, 8);
    check_stream("t5", 6);
    @(posedge clk); #2;
    start = 1'b1; abort = 1'b1; len_m1 = 4'd2;
    @(posedge clk); #2;
    start = 1'b0; abort = 1'b0;
    #1;
    check("t5_idle_sa_busy", busy, 0);
    do_start(4'd5, sc);
    @(posedge clk); #2;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; abort = 1'b0;
    #1;
    check("t5_run_sa_busy", busy, 0);
    check("t5_run_sa_valid", out_valid, 0);
    check("t5_run_sa_sel", Sel, 0);
    repeat (3) @(posedge clk);
    #1 check("t5_stays_idle", busy, 0);

    // Asynchronous reset mid-pass.
    for (int i = 0; i < 16; i++) d_mem[i] = 16'h6000 + 16'(i);
    do_start(4'd15, sc);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_sel", Sel, 0);
    check("t6_rst_data", out_data, 0);
    check("t6_rst_last", out_last, 0);
    check("t6_rst_done", done, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_post_busy", busy, 0);
    check("t6_post_valid", out_valid, 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ann_input_sequencer.md
# ann_input_sequencer

Controller for the ANN input-selection datapath: it drives the 4-bit select of the 16-to-1 16-bit input mux, steps it through a programmable number of inputs, and streams each selected word to the downstream MAC stage over a valid/ready handshake. It sits between the layer control FSM (start/done) and the MAC unit. The input mux stays purely combinational; this block owns all sequencing and stall behaviour.

## Interface
- `N_IN`, 16, maximum inputs per pass; fixed at 16 (select width 4)
- `DW`, 16, data width of mux output and stream
- `clk` input 1, single clock, rising edge
- `rst_n` input 1, asynchronous active-low reset
- `start` input 1, pulse; begins a pass when idle
- `abort` input 1, synchronous cancel of the pass in progress
- `len_m1` input 4, number of inputs in the pass minus 1 (0 → 1 input, 15 → 16 inputs); sampled on accepted `start`
- `Sel` output 4, select to the 16-to-1 mux (0 selects D1, 15 selects D16)
- `mux_d` input DW, combinational mux output D for the current `Sel`
- `out_data` output DW, registered stream word
- `out_valid` output 1, `out_data` holds a word
- `out_ready` input 1, downstream accepts the word this cycle
- `out_last` output 1, qualifies the final word of the pass
- `busy` output 1, a pass is in progress (state ≠ IDLE)
- `done` output 1, one-cycle pulse after the last word is accepted

## Operation
- States: IDLE, RUN, LAST.
- IDLE:
  - `start`=1 → latch `len_m1` into `len_r`, `Sel`←0, go to RUN.
  - `start` while not IDLE is ignored.
- RUN, load condition `ld = !out_valid || out_ready`. When `ld`:
  - `out_data`←`mux_d`, `out_valid`←1, `out_last`←(`Sel`==`len_r`).
  - If `Sel`==`len_r`, go to LAST with `Sel` held; otherwise `Sel`←`Sel`+1.
  - When `!ld` (stall): `Sel`, `out_data`, `out_valid` and `out_last` hold.
- LAST: on `out_valid && out_ready`, clear `out_valid` and `out_last`, pulse `done`, return to IDLE, set `Sel`←0.
- `Sel` never wraps past `len_r`. With `len_r`=15 the pass ends at 15, so no 4-bit overflow occurs.
- `out_data` is not reset on handshake; it keeps its last value while `out_valid`=0.
- `abort`, in any state: next state IDLE, `out_valid`←0, `out_last`←0, `Sel`←0, no `done`. `abort` has priority over `start` in the same cycle.
- Reset (`rst_n`=0, asynchronous, any time including mid-pass): state IDLE, `Sel`=0, `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0.
- `busy` is a decode of the state. `done` is a registered pulse, high exactly one cycle.

## Timing
- `start` sampled at edge t:
  - `Sel`=0 and `busy`=1 after edge t.
  - First word (D1) registered at edge t+1; `out_valid`=1 after t+1.
- With `out_ready` held 1: one word per cycle. Word k (0-based) is valid after edge t+1+k, last word after edge t+1+`len_m1`.
- The last word's handshake at edge t+2+`len_m1` clears `out_valid`. `done`=1 and `busy`=0 for the following cycle.
- Pass latency: `start` to `done` high is `len_m1`+3 cycles with no stalls. Each stalled cycle adds exactly one.
- Back-to-back passes: `start` is accepted in the cycle `done` is high (state is IDLE). There is no overlap between passes.
- `mux_d` must settle within one cycle of a `Sel` change. The mux adds no pipeline stage.

## Test plan
- Reset then `start` with `len_m1`=15, `out_ready`=1, D1..D16=16'h0001..16'h0010 → 16 words 0x0001..0x0010 on consecutive cycles; `out_last` only on 0x0010; `done` pulse 18 cycles after `start`.
- `len_m1`=0 → single word D1 with `out_last`=1; `Sel` stays 0; `done` 3 cycles after `start`.
- `len_m1`=7, `out_ready` toggling 1,0,0,1,… → `Sel` and `out_data` stable during every low-ready cycle; exactly 8 words D1..D8 in order, none dropped or duplicated.
- `abort` asserted on the 5th word of a 16-word pass → `out_valid`=0, `busy`=0, `Sel`=0 next cycle; no `done`. A new `start` with `len_m1`=3 then streams D1..D4.
- `start` pulsed while busy, and `start` asserted together with `abort` → ignored in both cases; the running pass output is unchanged, or the block returns to IDLE respectively.
- `rst_n` dropped asynchronously mid-pass between clock edges → all outputs 0 immediately; after release the block is idle until the next `start`.
